// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Pipeline request/response bus plus data-memory port of the
//            MEM-stage access unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_load;
  logic              dm_str;
  logic              dm_sel;
  logic [31:0]       dm_rdata;

  // The access unit itself.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  dm_rdata,
    output stall, rsp_valid, rsp_err, rsp_rdata,
    output dm_addr, dm_wdata, dm_load, dm_str, dm_sel
  );

  // The pipeline and data memory around it.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output dm_rdata,
    input  stall, rsp_valid, rsp_err, rsp_rdata,
    input  dm_addr, dm_wdata, dm_load, dm_str, dm_sel
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage byte/halfword/word load-store initiator for a 32-bit
//            word-addressed data memory; sub-word stores use read-modify-write.
//            Optional macro BOUNDS_CHECK_EN flags addresses above the memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input  wire logic         clk,
  input  wire logic         clr,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic [31:0] c_BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] c_HALF_MASK = 32'h0000_FFFF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;
  logic [31:0]       r_merge;
  logic [ADDR_W-1:0] r_addr;

  logic [ADDR_W-1:0] w_idx;
  logic              w_misalign;
  logic              w_oob;
  logic              w_err;
  logic [4:0]        w_shift;
  logic [31:0]       w_lane;
  logic [31:0]       w_ext;
  logic [31:0]       w_size_mask;
  logic [31:0]       w_merged;
  logic              w_done;
  logic              w_done_err;
  logic              w_cap_load;
  logic              w_cap_merge;
  logic              w_dm_load;
  logic              w_dm_str;
  logic              w_dm_sel;
  logic              w_stall;
  logic [ADDR_W-1:0] w_dm_addr;
  logic [31:0]       w_dm_wdata;

  assign w_idx      = bus.req_addr[ADDR_W+1:2];
  assign w_misalign = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

`ifdef BOUNDS_CHECK_EN
  assign w_oob = |bus.req_addr[31:ADDR_W+2];
`else
  // Upper bits alias onto the memory and take no part in decoding.
  logic w_unused_hi;
  assign w_unused_hi = |bus.req_addr[31:ADDR_W+2];
  assign w_oob       = 1'b0;
`endif

  assign w_err = w_misalign || w_oob;

  // Byte offset drives both load lane extraction and store lane insertion.
  assign w_shift     = {bus.req_addr[1:0], 3'b000};
  assign w_lane      = bus.dm_rdata >> w_shift;
  assign w_size_mask = (bus.req_size == 2'b00) ? c_BYTE_MASK : c_HALF_MASK;
  assign w_merged    = (bus.dm_rdata & ~(w_size_mask << w_shift)) |
                       ((bus.req_wdata & w_size_mask) << w_shift);

  always_comb begin
    w_ext = w_lane;
    case (bus.req_size)
      2'b00:   w_ext = {{24{~bus.req_unsigned & w_lane[7]}},  w_lane[7:0]};
      2'b01:   w_ext = {{16{~bus.req_unsigned & w_lane[15]}}, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_cap_load  = 1'b0;
    w_cap_merge = 1'b0;
    w_dm_load   = 1'b0;
    w_dm_str    = 1'b0;
    w_dm_sel    = 1'b0;
    w_stall     = 1'b0;
    w_dm_addr   = (r_state == S_WRITE) ? r_addr  : w_idx;
    w_dm_wdata  = (r_state == S_WRITE) ? r_merge : bus.req_wdata;
    if (!clr) begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (w_err) begin
              w_done     = 1'b1;
              w_done_err = 1'b1;
            end else if (!bus.req_we) begin
              w_dm_load  = 1'b1;
              w_dm_sel   = 1'b1;
              w_cap_load = 1'b1;
              w_done     = 1'b1;
            end else if (bus.req_size == 2'b10) begin
              w_dm_str = 1'b1;
              w_dm_sel = 1'b1;
              w_done   = 1'b1;
            end else begin
              w_dm_load   = 1'b1;
              w_dm_sel    = 1'b1;
              w_stall     = 1'b1;
              w_cap_merge = 1'b1;
              w_state_nxt = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          w_dm_str    = 1'b1;
          w_dm_sel    = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_merge     <= 32'h0;
      r_addr      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_done;
      r_rsp_err   <= w_done_err;
      if (w_cap_load) begin
        r_rsp_rdata <= w_ext;
      end
      if (w_cap_merge) begin
        r_merge <= w_merged;
        r_addr  <= w_idx;
      end
    end
  end

  assign bus.stall     = w_stall;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.dm_addr   = w_dm_addr;
  assign bus.dm_wdata  = w_dm_wdata;
  assign bus.dm_load   = w_dm_load;
  assign bus.dm_str    = w_dm_str;
  assign bus.dm_sel    = w_dm_sel;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit against a byte-array model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int ADDR_W = 6;
  localparam int NWORDS = 1 << ADDR_W;
  localparam int NBYTES = NWORDS * 4;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk     = 1'b0;
  logic clr     = 1'b1;
  logic do_init = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic [31:0] mem_w  [NWORDS];
  logic [31:0] init_w [NWORDS];

  always @(posedge clk) begin
    if (do_init) begin
      for (int k = 0; k < NWORDS; k++) mem_w[k] <= init_w[k];
    end else if (bus.dm_str && bus.dm_sel) begin
      mem_w[bus.dm_addr] <= bus.dm_wdata;
    end
  end

  assign bus.dm_rdata = (bus.dm_load && bus.dm_sel) ? mem_w[bus.dm_addr] : 32'h0;

  logic [7:0]  ref_b [NBYTES];
  logic [31:0] last_rdata;
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endfunction

  function automatic logic ref_err(logic [31:0] a, logic [1:0] sz);
    logic r;
    r = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef BOUNDS_CHECK_EN
    r = r || (a[31:ADDR_W+2] != '0);
`endif
    return r;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] sz, logic u);
    int          i;
    logic [15:0] h;
    i = int'(a[ADDR_W+1:0]);
    h = {ref_b[(i+1) % NBYTES], ref_b[i]};
    case (sz)
      2'd0:    return u ? {24'h0, ref_b[i]} : {{24{ref_b[i][7]}}, ref_b[i]};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {ref_b[i+3], ref_b[i+2], ref_b[i+1], ref_b[i]};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    int i;
    i = int'(a[ADDR_W+1:0]);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_b[i+k] = wd[8*k +: 8];
  endtask

  // Scoreboard monitor: every response pops one expectation.
  always @(negedge clk) begin
    if (!clr) begin
      chk("load_str_exclusive", 32'(bus.dm_load & bus.dm_str), 32'h0);
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_err",   32'(bus.rsp_err), 32'(mon_e.err));
          chk("rsp_rdata", bus.rsp_rdata,    mon_e.rdata);
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    logic              e;
    logic              exp_stall;
    logic [ADDR_W-1:0] idx;
    exp_t              x;
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    e         = ref_err(a, sz);
    idx       = a[ADDR_W+1:2];
    exp_stall = we && !e && (sz != 2'd2);
    x.err     = e;
    if (!e && !we) last_rdata = ref_load(a, sz, u);
    if (!e && we)  ref_store(a, sz, wd);
    x.rdata = last_rdata;
    exp_q.push_back(x);
    @(negedge clk);
    chk("stall",  32'(bus.stall),  32'(exp_stall));
    chk("dm_sel", 32'(bus.dm_sel), 32'(!e));
    if (!e) chk("dm_addr", 32'(bus.dm_addr), 32'(idx));
    if (exp_stall) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rmw_str",   32'(bus.dm_str),  32'h1);
      chk("rmw_stall", 32'(bus.stall),   32'h0);
      chk("rmw_addr",  32'(bus.dm_addr), 32'(idx));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = $urandom;
      @(negedge clk);
      chk("idle_sel", 32'(bus.dm_sel), 32'h0);
    end
  endtask

  task automatic idle_expect(input logic [31:0] v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("directed_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("directed_rdata",     bus.rsp_rdata,      v);
  endtask

  task automatic clr_in_write();
    @(posedge clk); #1;
    bus.req_valid = 1'b1;  bus.req_we   = 1'b1;     bus.req_size  = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    chk("clr_str",   32'(bus.dm_str),  32'h0);
    chk("clr_stall", 32'(bus.stall),   32'h0);
    @(posedge clk); #1;
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    last_rdata    = 32'h0;
    @(negedge clk);
    chk("clr_no_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("clr_rdata",  bus.rsp_rdata,      32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic        u;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] a;
    for (int w = 0; w < NWORDS; w++) init_w[w] = $urandom;
    init_w[0] = 32'h1122_3344;
    for (int w = 0; w < NWORDS; w++)
      for (int k = 0; k < 4; k++) ref_b[4*w+k] = init_w[w][8*k +: 8];
    last_rdata = 32'h0;

    // A live load request during reset must produce no strobes.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",   32'(bus.stall),   32'h0);
    chk("rst_dm_load", 32'(bus.dm_load), 32'h0);
    chk("rst_dm_str",  32'(bus.dm_str),  32'h0);
    chk("rst_dm_sel",  32'(bus.dm_sel),  32'h0);
    @(posedge clk); #1;
    clr = 1'b0; do_init = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'h0);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    idle_expect(32'hDEAD_BEEF);
    idle(1);
    chk("word4_store", mem_w[4], 32'hDEAD_BEEF);

    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h80);
    idle(2);
    chk("word4_byte", mem_w[4], 32'hDEAD_80EF);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    idle_expect(32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    idle_expect(32'h0000_0080);

    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
    idle(2);
    chk("word4_half", mem_w[4], 32'h1234_80EF);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    idle_expect(32'h0000_1234);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    idle_expect(32'hFFFF_80EF);

    do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF);
    idle(2);
    chk("word4_err", mem_w[4], 32'h1234_80EF);

    clr_in_write();
    idle(2);
    chk("word4_clr", mem_w[4], 32'h1234_80EF);

    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    idle(1);

    repeat (400) begin
      we  = 1'($urandom);
      u   = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off = 2'($urandom);
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) off[0] = 1'b0;
        if (sz == 2'd2) off    = 2'd0;
      end
      a = {($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'h0, 6'($urandom), off};
      do_req(we, sz, u, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    for (int w = 0; w < NWORDS; w++)
      chk("mem_final", mem_w[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
